write_rptr_sync_level: RTL and testbench

- Write-domain receiving end of the read-pointer crossing in the async FIFO.
- Synchronises the Gray-coded read pointer from the read domain into write_clk and drives sync_read_ptr to the write-side full logic.
- Derives write-side fill level, almost-full, and a freed-slot pulse from the synchronised pointer and the local Gray write pointer.
- Sits between the read-pointer generator (read domain) and the write-side full/increment logic.

---
 rtl/write_rptr_sync_level_if.sv | 48 ++++
 rtl/write_rptr_sync_level.sv | 130 +++++++++++++
 tb/tb_write_rptr_sync_level.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/write_rptr_sync_level_if.sv
// ---------------------------------------------------------------------------
// write_rptr_sync_level_if
// Purpose : bundles the pointer inputs and the derived write-side status of
//           the read-pointer crossing into one port.
// Signals : read_ptr          Gray read pointer from the read domain
//           write_ptr         Gray write pointer, registered in write domain
//           sync_read_ptr     read pointer after the synchroniser
//           read_bin          binary form of sync_read_ptr
//           write_level       occupancy seen from the write side
//           write_almost_full level at or above the almost-full threshold
//           read_moved        one-cycle pulse when the read pointer advanced
//           gray_err          sticky protocol error flag
// Modports: master drives the pointers, slave (the block) drives status.
// ---------------------------------------------------------------------------
interface write_rptr_sync_level_if #(
  parameter int ADDRESS = 3
);
  logic [ADDRESS:0] read_ptr;
  logic [ADDRESS:0] write_ptr;
  logic [ADDRESS:0] sync_read_ptr;
  logic [ADDRESS:0] read_bin;
  logic [ADDRESS:0] write_level;
  logic             write_almost_full;
  logic             read_moved;
  logic             gray_err;

  modport master (
    output read_ptr,
    output write_ptr,
    input  sync_read_ptr,
    input  read_bin,
    input  write_level,
    input  write_almost_full,
    input  read_moved,
    input  gray_err
  );

  modport slave (
    input  read_ptr,
    input  write_ptr,
    output sync_read_ptr,
    output read_bin,
    output write_level,
    output write_almost_full,
    output read_moved,
    output gray_err
  );
endinterface

// File: rtl/write_rptr_sync_level.sv
// ---------------------------------------------------------------------------
// write_rptr_sync_level
// Purpose : write-domain receiver of the async FIFO read pointer. Brings the
//           Gray read pointer into write_clk through a flop chain, then
//           derives the write-side fill level, almost-full flag and a
//           freed-slot pulse against the local Gray write pointer.
// Ports   : write_clk  write-domain clock
//           write_rst  asynchronous active-high reset
//           bus        write_rptr_sync_level_if.slave (pointers in, status out)
// Params  : ADDRESS      FIFO address width, pointers are ADDRESS+1 bits
//           SYNC_STAGES  synchroniser depth, 2..4
//           AFULL_THRESH almost-full level, 1..2**ADDRESS
// Option  : define WRPTR_GRAY_CHECK_EN to build the sticky gray_err checker;
//           otherwise gray_err is tied low and no checker logic exists.
// ---------------------------------------------------------------------------
module write_rptr_sync_level #(
  parameter int ADDRESS      = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input logic                     write_clk,
  input logic                     write_rst,
  write_rptr_sync_level_if.slave  bus
);

  localparam logic [ADDRESS:0] AfullThreshW = (ADDRESS+1)'(AFULL_THRESH);

  logic [SYNC_STAGES-1:0][ADDRESS:0] syncStage_q;
  logic [ADDRESS:0]                  prevRead_q;
  logic [ADDRESS:0]                  readBin_q;
  logic [ADDRESS:0]                  readBin_d;
  logic [ADDRESS:0]                  writeLevel_q;
  logic [ADDRESS:0]                  writeLevel_d;
  logic [ADDRESS:0]                  writeBin;
  logic                              almostFull_q;
  logic                              almostFull_d;
  logic                              readMoved_q;
  logic                              readMoved_d;
  logic [ADDRESS:0]                  syncRead;

  function automatic logic [ADDRESS:0] gray2bin(input logic [ADDRESS:0] g);
    logic [ADDRESS:0] b;
    b[ADDRESS] = g[ADDRESS];
    for (int i = ADDRESS - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain; only one bit of the Gray pointer moves per step, so
  // no logic may sit between stages.
  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      syncStage_q <= '0;
    end else begin
      syncStage_q[0] <= bus.read_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncStage_q[i] <= syncStage_q[i-1];
      end
    end
  end

  assign syncRead = syncStage_q[SYNC_STAGES-1];

  // Level is a modular subtraction of binary pointers; the extra MSB makes
  // wrap-around of either pointer come out right with no special case.
  always_comb begin
    readBin_d    = gray2bin(syncRead);
    writeBin     = gray2bin(bus.write_ptr);
    writeLevel_d = writeBin - readBin_d;
    almostFull_d = (writeLevel_d >= AfullThreshW);
    readMoved_d  = (syncRead != prevRead_q);
  end

  // Status registers all update on the edge after sync_read_ptr changes,
  // so read_bin, write_level, almost-full and read_moved stay aligned.
  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      prevRead_q   <= '0;
      readBin_q    <= '0;
      writeLevel_q <= '0;
      almostFull_q <= 1'b0;
      readMoved_q  <= 1'b0;
    end else begin
      prevRead_q   <= syncRead;
      readBin_q    <= readBin_d;
      writeLevel_q <= writeLevel_d;
      almostFull_q <= almostFull_d;
      readMoved_q  <= readMoved_d;
    end
  end

`ifdef WRPTR_GRAY_CHECK_EN
  localparam logic [ADDRESS:0] DepthW = (ADDRESS+1)'(2**ADDRESS);

  logic             grayErr_q;
  logic             grayErr_d;
  logic [ADDRESS:0] ptrDiff;

  // A legal Gray step flips at most one bit (x & (x-1) clears the lowest
  // set bit); a level beyond the FIFO depth means the pointers disagree.
  always_comb begin
    ptrDiff   = syncRead ^ prevRead_q;
    grayErr_d = grayErr_q;
    if (((ptrDiff & (ptrDiff - 1'b1)) != '0) || (writeLevel_d > DepthW)) begin
      grayErr_d = 1'b1;
    end
  end

  // Sticky until reset so a transient glitch is never lost.
  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      grayErr_q <= 1'b0;
    end else begin
      grayErr_q <= grayErr_d;
    end
  end

  assign bus.gray_err = grayErr_q;
`else
  assign bus.gray_err = 1'b0;
`endif

  assign bus.sync_read_ptr     = syncRead;
  assign bus.read_bin          = readBin_q;
  assign bus.write_level       = writeLevel_q;
  assign bus.write_almost_full = almostFull_q;
  assign bus.read_moved        = readMoved_q;

endmodule

// File: tb/tb_write_rptr_sync_level.sv
// ---------------------------------------------------------------------------
// tb_write_rptr_sync_level
// Purpose : directed bench for write_rptr_sync_level with ADDRESS=3,
//           SYNC_STAGES=2, AFULL_THRESH=6. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_write_rptr_sync_level;

  logic write_clk;
  logic write_rst;
  int   checkCount;
  int   errorCount;
  logic expGrayErr;

  write_rptr_sync_level_if #(.ADDRESS(3)) bus ();

  write_rptr_sync_level #(
    .ADDRESS      (3),
    .SYNC_STAGES  (2),
    .AFULL_THRESH (6)
  ) dut (
    .write_clk (write_clk),
    .write_rst (write_rst),
    .bus       (bus)
  );

  // Free-running 10 ns write clock.
  initial begin
    write_clk = 1'b0;
    forever #5 write_clk = ~write_clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and land 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge write_clk);
    #1;
  endtask

  // Drive both Gray pointers from the bench.
  task automatic applyStimulus(input logic [3:0] rp, input logic [3:0] wp);
    bus.read_ptr  = rp;
    bus.write_ptr = wp;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".sync"},  32'(bus.sync_read_ptr), 0);
    checkOutput({tag, ".bin"},   32'(bus.read_bin), 0);
    checkOutput({tag, ".level"}, 32'(bus.write_level), 0);
    checkOutput({tag, ".afull"}, 32'(bus.write_almost_full), 0);
    checkOutput({tag, ".moved"}, 32'(bus.read_moved), 0);
    checkOutput({tag, ".gerr"},  32'(bus.gray_err), 0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
`ifdef WRPTR_GRAY_CHECK_EN
    expGrayErr = 1'b1;
`else
    expGrayErr = 1'b0;
`endif

    // Power-on reset.
    write_rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    tick(2);
    checkAllZero("por");
    write_rst = 1'b0;

    // Load a non-zero state: read 0101 (bin 6), write 0 -> level 10.
    applyStimulus(4'b0101, 4'b0000);
    tick(4);
    checkOutput("pre.sync",  32'(bus.sync_read_ptr), 5);
    checkOutput("pre.bin",   32'(bus.read_bin), 6);
    checkOutput("pre.level", 32'(bus.write_level), 10);
    checkOutput("pre.afull", 32'(bus.write_almost_full), 1);
    checkOutput("pre.gerr",  32'(bus.gray_err), 32'(expGrayErr));

    // Reset asserted mid-cycle must clear outputs without a clock edge.
    #2;
    write_rst = 1'b1;
    #1;
    checkAllZero("asyncrst");
    applyStimulus(4'b0000, 4'b0000);
    tick(1);
    write_rst = 1'b0;
    tick(4);
    checkAllZero("postrst");

    // Write 0011 (bin 2) ahead of read 0 -> level 2.
    applyStimulus(4'b0000, 4'b0011);
    tick(2);
    checkOutput("wr2.level", 32'(bus.write_level), 2);
    checkOutput("wr2.afull", 32'(bus.write_almost_full), 0);

    // Latency: read 0000 -> 0001.
    applyStimulus(4'b0001, 4'b0011);
    tick(1);
    checkOutput("lat.e1.sync",  32'(bus.sync_read_ptr), 0);
    tick(1);
    checkOutput("lat.e2.sync",  32'(bus.sync_read_ptr), 1);
    checkOutput("lat.e2.bin",   32'(bus.read_bin), 0);
    checkOutput("lat.e2.moved", 32'(bus.read_moved), 0);
    tick(1);
    checkOutput("lat.e3.bin",   32'(bus.read_bin), 1);
    checkOutput("lat.e3.moved", 32'(bus.read_moved), 1);
    checkOutput("lat.e3.level", 32'(bus.write_level), 1);
    tick(1);
    checkOutput("lat.e4.moved", 32'(bus.read_moved), 0);

    // One below threshold: write 0111 (bin 5), read 0 -> level 5.
    applyStimulus(4'b0000, 4'b0111);
    tick(4);
    checkOutput("lvl5.level", 32'(bus.write_level), 5);
    checkOutput("lvl5.afull", 32'(bus.write_almost_full), 0);

    // Threshold rising: write 0101 (bin 6) -> level 6.
    applyStimulus(4'b0000, 4'b0101);
    tick(4);
    checkOutput("rise.level", 32'(bus.write_level), 6);
    checkOutput("rise.afull", 32'(bus.write_almost_full), 1);

    // Threshold falling: read 0011 (bin 2) -> level 4 three edges later.
    applyStimulus(4'b0011, 4'b0101);
    tick(2);
    checkOutput("fall.e2.level", 32'(bus.write_level), 6);
    tick(1);
    checkOutput("fall.e3.level", 32'(bus.write_level), 4);
    checkOutput("fall.e3.afull", 32'(bus.write_almost_full), 0);

    // Wrap: write 0001 (bin 1), read 1011 (bin 13) -> level 4.
    applyStimulus(4'b1011, 4'b0001);
    tick(4);
    checkOutput("wrap1.bin",   32'(bus.read_bin), 13);
    checkOutput("wrap1.level", 32'(bus.write_level), 4);
    checkOutput("wrap1.afull", 32'(bus.write_almost_full), 0);

    // Full FIFO: write 1100 (bin 8), read 0 -> level 8.
    applyStimulus(4'b0000, 4'b1100);
    tick(4);
    checkOutput("wrap2.sync",  32'(bus.sync_read_ptr), 0);
    checkOutput("wrap2.level", 32'(bus.write_level), 8);
    checkOutput("wrap2.afull", 32'(bus.write_almost_full), 1);

    // Gray error: fresh reset, then read jumps 0000 -> 0011 (two bits).
    write_rst = 1'b1;
    applyStimulus(4'b0000, 4'b0010);
    tick(1);
    write_rst = 1'b0;
    tick(3);
    checkOutput("gray.pre", 32'(bus.gray_err), 0);
    applyStimulus(4'b0011, 4'b0010);
    tick(2);
    checkOutput("gray.e2", 32'(bus.gray_err), 0);
    tick(1);
    checkOutput("gray.e3", 32'(bus.gray_err), 32'(expGrayErr));
    checkOutput("gray.e3.moved", 32'(bus.read_moved), 1);
    applyStimulus(4'b0010, 4'b0010);
    tick(4);
    checkOutput("gray.sticky", 32'(bus.gray_err), 32'(expGrayErr));
    checkOutput("gray.level",  32'(bus.write_level), 0);
    write_rst = 1'b1;
    #1;
    checkOutput("gray.rst", 32'(bus.gray_err), 0);
    write_rst = 1'b0;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
